// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the CPU mem-stage dmem_* interface.
// It owns a word-organised, little-endian RAM and performs byte, halfword and
// word accesses. Loads are sign- or zero-extended. Each access completes with a
// one-cycle dmem_drdy pulse, WAIT_CYCLES + 1 cycles after the request is sampled.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   dmem_addr         byte address
//   dmem_wdata        store data, right-aligned
//   dmem_write/read   store / load request (both set = store)
//   dmem_rdu          unsigned load (zero-extend)
//   dmem_byte/hwrd/wrd access size, priority wrd > hwrd > byte, none = word
//   dmem_drdy         one-cycle completion pulse
//   dmem_rdata        extended load data, valid with dmem_drdy
//   dmem_err          access error, valid with dmem_drdy (DMEM_ERR_EN only)
//
// Optional feature macro: DMEM_ERR_EN. When it is defined, misaligned or
// out-of-range accesses flag dmem_err, suppress the store and return zero.
// When it is undefined, misaligned accesses are aligned and high address bits
// alias.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_write,
  input  logic        dmem_read,
  input  logic        dmem_rdu,
  input  logic        dmem_byte,
  input  logic        dmem_hwrd,
  input  logic        dmem_wrd,
  output logic        dmem_drdy,
  output logic [31:0] dmem_rdata
`ifdef DMEM_ERR_EN
  ,
  output logic        dmem_err
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  // Request copy captured in IDLE; used while the FSM is in WAIT.
  logic [31:0] addr_q, wdata_q;
  logic        wrd_q, hwrd_q, byte_q, rdu_q, wr_q;

  logic [31:0] mem [DEPTH];

  // Access fields: straight from the inputs when RESP is entered from IDLE,
  // otherwise from the latched copy.
  logic [31:0]   acc_addr, acc_wdata;
  logic          acc_wrd, acc_hwrd, acc_byte, acc_rdu, acc_wr;
  logic          is_word, is_half, is_byte, acc_err, commit;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word, wr_word, ld_data;
  logic [3:0]    be;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = dmem_addr;
      acc_wdata = dmem_wdata;
      acc_wrd   = dmem_wrd;
      acc_hwrd  = dmem_hwrd;
      acc_byte  = dmem_byte;
      acc_rdu   = dmem_rdu;
      acc_wr    = dmem_write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wrd   = wrd_q;
      acc_hwrd  = hwrd_q;
      acc_byte  = byte_q;
      acc_rdu   = rdu_q;
      acc_wr    = wr_q;
    end
  end

  assign is_word  = acc_wrd | ~(acc_hwrd | acc_byte);
  assign is_half  = ~acc_wrd & acc_hwrd;
  assign is_byte  = ~acc_wrd & ~acc_hwrd & acc_byte;
  assign lane     = acc_addr[1:0];
  assign word_idx = acc_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

`ifdef DMEM_ERR_EN
  assign acc_err = (is_half & lane[0]) | (is_word & (lane != 2'b00)) |
                   (acc_addr[31:AW+2] != '0);
`else
  logic unused_bits;
  assign acc_err     = 1'b0;
  assign unused_bits = ^{acc_addr[31:AW+2], err_q};
`endif

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dmem_read | dmem_write) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end
  end

  // Store and load-capture both happen on the edge entering RESP; a reset
  // forces state_d to IDLE, which cancels the commit.
  assign commit = (state_d == StResp) && (state_q != StResp);

  // Store lane enables and right-aligned data replicated across lanes
  always_comb begin
    if (is_byte) begin
      be      = 4'b0001 << lane;
      wr_word = {4{acc_wdata[7:0]}};
    end else if (is_half) begin
      be      = lane[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{acc_wdata[15:0]}};
    end else begin
      be      = 4'b1111;
      wr_word = acc_wdata;
    end
  end

  // Load extraction and extension
  always_comb begin
    ld_b = rd_word[{lane, 3'b000} +: 8];
    ld_h = lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (acc_wr || acc_err) begin
      ld_data = 32'd0;
    end else if (is_byte) begin
      ld_data = {{24{~acc_rdu & ld_b[7]}}, ld_b};
    end else if (is_half) begin
      ld_data = {{16{~acc_rdu & ld_h[15]}}, ld_h};
    end else begin
      ld_data = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && acc_wr && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= ld_data;
        err_q   <= acc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && (dmem_read | dmem_write)) begin
      addr_q  <= dmem_addr;
      wdata_q <= dmem_wdata;
      wrd_q   <= dmem_wrd;
      hwrd_q  <= dmem_hwrd;
      byte_q  <= dmem_byte;
      rdu_q   <= dmem_rdu;
      wr_q    <= dmem_write;
    end
  end

  assign dmem_drdy  = (state_q == StResp);
  assign dmem_rdata = rdata_q;
`ifdef DMEM_ERR_EN
  assign dmem_err   = err_q & dmem_drdy;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: dut0 runs with WAIT_CYCLES=0, dut1 with
// WAIT_CYCLES=3. The drivers push expected responses into per-DUT queues; a
// negedge monitor pops and checks each drdy pulse (data, err, latency, width).
module tb_dmem_responder;

  localparam int unsigned Depth = 256;
  localparam logic [2:0]  SzW = 3'b100, SzH = 3'b010, SzB = 3'b001, SzN = 3'b000;

  typedef struct packed {
    logic [31:0] data;
    logic        chk;
    logic        err;
    logic [31:0] lat;
    logic [31:0] issue;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, rd, wr, rdu, szb, szh, szw, drdy, err;
  logic [1:0][31:0] addr, wdata, rdata;

  exp_t q0[$], q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [1:0] drdy_prev = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_write(wr[0]), .dmem_read(rd[0]), .dmem_rdu(rdu[0]), .dmem_byte(szb[0]),
    .dmem_hwrd(szh[0]), .dmem_wrd(szw[0]), .dmem_drdy(drdy[0]), .dmem_rdata(rdata[0])
`ifdef DMEM_ERR_EN
    , .dmem_err(err[0])
`endif
  );

  dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(3), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_write(wr[1]), .dmem_read(rd[1]), .dmem_rdu(rdu[1]), .dmem_byte(szb[1]),
    .dmem_hwrd(szh[1]), .dmem_wrd(szw[1]), .dmem_drdy(drdy[1]), .dmem_rdata(rdata[1])
`ifdef DMEM_ERR_EN
    , .dmem_err(err[1])
`endif
  );

`ifndef DMEM_ERR_EN
  assign err = 2'b00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_drdy dut%0d: got drdy 1, required 0 (no request pending)", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("latency dut%0d", d), 32'(cyc) - e.issue, e.lat);
    check($sformatf("drdy_single_pulse dut%0d", d), 32'(drdy_prev[d]), 32'd0);
    if (e.chk) check($sformatf("rdata dut%0d", d), rdata[d], e.data);
`ifdef DMEM_ERR_EN
    check($sformatf("err dut%0d", d), 32'(err[d]), 32'(e.err));
`endif
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (drdy[d]) mon(d);
    end
    drdy_prev <= drdy;
  end

  // Issues one request on DUT d and holds it until drdy. toggle flips address
  // bit 6 every waiting cycle; rst_at > 0 asserts reset in that cycle instead.
  task automatic access(input int d, input logic r, input logic w, input logic u,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic chk, input logic [31:0] exp_data, input logic exp_err,
                        input logic toggle, input int rst_at);
    exp_t e;
    @(negedge clk);
    rd[d] = r; wr[d] = w; rdu[d] = u; addr[d] = a; wdata[d] = wd;
    {szw[d], szh[d], szb[d]} = sz;
    e.data  = exp_data;
    e.chk   = chk;
    e.err   = exp_err;
    e.lat   = (d == 0) ? 32'd1 : 32'd4;
    e.issue = 32'(cyc);
    if (rst_at <= 0) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (drdy[d]) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
        return;
      end
      if (rst_at > 0 && k == rst_at) begin
        rst[d] = 1'b1;
      end else if (rst_at > 0 && k == rst_at + 1) begin
        rst[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
        return;
      end
      if (toggle) addr[d] = addr[d] ^ 32'h40;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    check($sformatf("drdy_timeout dut%0d", d), 32'd0, 32'd1);
  endtask

  task automatic st(input int d, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] wd);
    access(d, 1'b0, 1'b1, 1'b0, sz, a, wd, 1'b0, 32'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic ld(input int d, input logic [2:0] sz, input logic u, input logic [31:0] a,
                    input logic [31:0] exp_data);
    access(d, 1'b1, 1'b0, u, sz, a, 32'd0, 1'b1, exp_data, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int seen;
    rst = 2'b11; rd = '0; wr = '0; rdu = '0; szb = '0; szh = '0; szw = '0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_drdy dut%0d", d), 32'(drdy[d]), 32'd0);
      check($sformatf("reset_rdata dut%0d", d), rdata[d], 32'd0);
`ifdef DMEM_ERR_EN
      check($sformatf("reset_err dut%0d", d), 32'(err[d]), 32'd0);
`endif
    end
    rst = 2'b00;

    // dut0: zero wait states
    st(0, SzW, 32'h10, 32'hDEADBEEF);
    ld(0, SzW, 1'b0, 32'h10, 32'hDEADBEEF);
    st(0, SzB, 32'h13, 32'h00000080);
    ld(0, SzB, 1'b0, 32'h13, 32'hFFFFFF80);
    ld(0, SzB, 1'b1, 32'h13, 32'h00000080);
    ld(0, SzW, 1'b0, 32'h10, 32'h80ADBEEF);
    ld(0, SzH, 1'b0, 32'h12, 32'hFFFF80AD);
    ld(0, SzH, 1'b1, 32'h12, 32'h000080AD);
    ld(0, SzB, 1'b0, 32'h11, 32'hFFFFFFBE);
    st(0, SzW, 32'h20, 32'h00000000);
    st(0, SzH, 32'h22, 32'hABCD1234);
    ld(0, SzH, 1'b1, 32'h20, 32'h00000000);
    ld(0, SzH, 1'b0, 32'h22, 32'h00001234);
    ld(0, SzW, 1'b0, 32'h20, 32'h12340000);
    // read and write together: a store that returns zero
    access(0, 1'b1, 1'b1, 1'b0, SzW, 32'h30, 32'h0BADF00D, 1'b1, 32'd0, 1'b0, 1'b0, 0);
    ld(0, SzN, 1'b0, 32'h30, 32'h0BADF00D);
    st(0, SzW | SzB, 32'h30, 32'h55667788);
    ld(0, SzW, 1'b0, 32'h30, 32'h55667788);
    st(0, SzW, 32'h00, 32'h01020304);
`ifdef DMEM_ERR_EN
    access(0, 1'b0, 1'b1, 1'b0, SzW, 32'h02, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, 1'b0, 0);
    ld(0, SzW, 1'b0, 32'h00, 32'h01020304);
    access(0, 1'b1, 1'b0, 1'b0, SzW, Depth * 4, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 0);
    access(0, 1'b1, 1'b0, 1'b0, SzH, 32'h21, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 0);
`else
    st(0, SzW, 32'h02, 32'hFFFFFFFF);
    ld(0, SzW, 1'b0, 32'h00, 32'hFFFFFFFF);
    ld(0, SzW, 1'b0, Depth * 4, 32'hFFFFFFFF);
    ld(0, SzH, 1'b1, 32'h23, 32'h00001234);
`endif

    // dut1: three wait states
    st(1, SzW, 32'h00, 32'hAAAA5555);
    st(1, SzW, 32'h40, 32'h11223344);
    access(1, 1'b1, 1'b0, 1'b0, SzW, 32'h40, 32'd0, 1'b1, 32'h11223344, 1'b0, 1'b1, 0);
    access(1, 1'b0, 1'b1, 1'b0, SzW, 32'h40, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0, 1'b0, 2);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (drdy[1]) seen++;
    end
    check("no_drdy_after_abort", 32'(seen), 32'd0);
    ld(1, SzW, 1'b0, 32'h40, 32'h11223344);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
